// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and
// a parameter-legality check used at elaboration time.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic bit params_ok(input int w, input int d);
      return (w >= 1) && (d >= 1) && (d <= w) && ((w % d) == 0);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, c, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, c, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, c
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, c
   );
`endif

endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full adders.
// Also exposes the carry into the top bit for overflow detection.
module digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_s,
   output logic             o_c,
   output logic             o_cmsb
);

   logic [DIGIT:0] w_cy;

   assign w_cy[0] = i_cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_cy[i];
      assign w_cy[i+1]  = (i_a[i] & i_b[i])
                        | (w_cy[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_c    = w_cy[DIGIT];
   assign o_cmsb = w_cy[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock through one reused ripple stage.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int SH   = WIDTH - DIGIT;

   if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             w_last;
   logic             w_accept;
   logic             w_in_ready;
   logic             w_out_valid;
   logic [DIGIT-1:0] w_ds;
   logic             w_dc;
   logic             w_cmsb;
   logic [WIDTH-1:0] w_snext;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .i_a   (r_a[DIGIT-1:0]),
      .i_b   (r_b[DIGIT-1:0]),
      .i_cin (r_carry),
      .o_s   (w_ds),
      .o_c   (w_dc),
      .o_cmsb(w_cmsb)
   );

   assign w_last   = (r_cnt == CW'(NDIG - 1));
   assign w_accept = (r_state == IDLE) && bus.in_valid;
   // New digit enters at the MSB end; after NDIG shifts it is in place.
   assign w_snext  = (r_s >> DIGIT) | (WIDTH'(w_ds) << SH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = RUN;
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_s     <= w_snext;
         r_carry <= w_dc;
         r_cnt   <= r_cnt + CW'(1);
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_ovf <= w_cmsb ^ w_dc;
      end else if (r_state == DONE && bus.out_ready) begin
         r_ovf <= 1'b0;
      end
   end

   assign bus.ovf = r_ovf;
`else
   logic w_unused_cmsb;
   assign w_unused_cmsb = w_cmsb;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.s         = r_s;
   assign bus.c         = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8/2 handshake, hold and reset cases,
// plus exhaustive 4-bit sweeps of the 4/4 and 4/1 configurations.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) bus8  ();
   serial_adder_if #(.WIDTH(4)) bus44 ();
   serial_adder_if #(.WIDTH(4)) bus41 ();

   serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8.slave)
   );
   serial_adder #(.WIDTH(4), .DIGIT(4)) dut44 (
      .clk(clk), .rst(rst), .bus(bus44.slave)
   );
   serial_adder #(.WIDTH(4), .DIGIT(1)) dut41 (
      .clk(clk), .rst(rst), .bus(bus41.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start8(input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
      @(negedge clk);
      chk("in_ready_idle", 32'(bus8.in_ready), 1);
      bus8.a        = a;
      bus8.b        = b;
      bus8.cin      = ci;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
   endtask

   task automatic wait8(input string tag);
      int n;
      n = 0;
      while (!bus8.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 4);
   endtask

   task automatic check8(input string tag, input logic [7:0] es,
                         input logic ec, input logic eo);
      chk({tag, "_s"}, 32'(bus8.s), 32'(es));
      chk({tag, "_c"}, 32'(bus8.c), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unknown ovf for %s", tag);
`endif
   endtask

   task automatic release8(input string tag);
      @(negedge clk);
      bus8.out_ready = 1'b1;
      @(posedge clk);
      #1 bus8.out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(bus8.out_valid), 0);
   endtask

   task automatic add8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec,
                       input logic eo);
      start8(a, b, ci);
      wait8(tag);
      check8(tag, es, ec, eo);
      release8(tag);
   endtask

   initial begin
      bus8.in_valid  = 1'b0;
      bus8.a         = '0;
      bus8.b         = '0;
      bus8.cin       = 1'b0;
      bus8.out_ready = 1'b0;
      bus44.in_valid = 1'b0;
      bus44.a        = '0;
      bus44.b        = '0;
      bus44.cin      = 1'b0;
      bus44.out_ready = 1'b0;
      bus41.in_valid = 1'b0;
      bus41.a        = '0;
      bus41.b        = '0;
      bus41.cin      = 1'b0;
      bus41.out_ready = 1'b0;

      #2;
      chk("rst_s", 32'(bus8.s), 0);
      chk("rst_c", 32'(bus8.c), 0);
      chk("rst_out_valid", 32'(bus8.out_valid), 0);
      chk("rst_in_ready", 32'(bus8.in_ready), 1);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(bus8.ovf), 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      add8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      add8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
      add8("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      add8("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

      // Result must stay frozen while the consumer stalls.
      start8(8'h80, 8'h80, 1'b1);
      wait8("hold");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus8.in_valid = ~bus8.in_valid;
         bus8.a        = 8'($urandom);
         bus8.b        = 8'($urandom);
         @(posedge clk);
         #1;
         chk("hold_s", 32'(bus8.s), 32'h01);
         chk("hold_c", 32'(bus8.c), 1);
         chk("hold_in_ready", 32'(bus8.in_ready), 0);
         chk("hold_out_valid", 32'(bus8.out_valid), 1);
      end
      bus8.in_valid = 1'b0;
      check8("hold_end", 8'h01, 1'b1, 1'b1);
      release8("hold");
      add8("after_hold", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      start8(8'h3C, 8'h0F, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrun_out_valid", 32'(bus8.out_valid), 0);
      chk("midrun_s", 32'(bus8.s), 0);
      chk("midrun_in_ready", 32'(bus8.in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      add8("after_rst", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               int n;
               int sum;
               sum = a + b + ci;
               @(negedge clk);
               bus44.a = 4'(a);
               bus44.b = 4'(b);
               bus44.cin = ci[0];
               bus44.in_valid = 1'b1;
               bus41.a = 4'(a);
               bus41.b = 4'(b);
               bus41.cin = ci[0];
               bus41.in_valid = 1'b1;
               @(posedge clk);
               #1;
               bus44.in_valid = 1'b0;
               bus41.in_valid = 1'b0;
               n = 0;
               while (!(bus44.out_valid && bus41.out_valid) && n < 10) begin
                  @(posedge clk);
                  #1;
                  n++;
               end
               chk("ex44", 32'({bus44.c, bus44.s}), 32'(sum));
               chk("ex41", 32'({bus41.c, bus41.s}), 32'(sum));
               @(negedge clk);
               bus44.out_ready = 1'b1;
               bus41.out_ready = 1'b1;
               @(posedge clk);
               #1;
               bus44.out_ready = 1'b0;
               bus41.out_ready = 1'b0;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
